// File: rtl/uop_dispatch_sched_if.sv
// Decode-queue, issue-slot, writeback and status signals of the uop dispatch scheduler.
// The master modport is the scheduler; the slave modport is its surrounding pipeline.
interface uop_dispatch_sched_if #(
    parameter int XLEN    = 32,
    parameter int STALL_W = 16
);
    logic               q_valid;
    logic               q_pop;
    logic [6:0]         q_uop;
    logic [XLEN-1:0]    q_imm;
    logic               q_use_imm;
    logic [XLEN-1:0]    q_pc;
    logic [4:0]         q_src1;
    logic [4:0]         q_src2;
    logic [4:0]         q_dest;

    logic               alu_valid;
    logic               alu_ready;
    logic [XLEN-1:0]    alu_iss_imm;
    logic               alu_iss_use_imm;
    logic [XLEN-1:0]    alu_iss_pc;
    logic [4:0]         alu_iss_src1;
    logic [4:0]         alu_iss_src2;
    logic [4:0]         alu_iss_dest;

    logic               mul_valid;
    logic               mul_ready;
    logic [XLEN-1:0]    mul_iss_imm;
    logic               mul_iss_use_imm;
    logic [XLEN-1:0]    mul_iss_pc;
    logic [4:0]         mul_iss_src1;
    logic [4:0]         mul_iss_src2;
    logic [4:0]         mul_iss_dest;

    logic [1:0]         wb_valid;
    logic [9:0]         wb_dest;
    logic               flush;
    logic               except_out;
    logic               halted;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        input  q_valid, q_uop, q_imm, q_use_imm, q_pc, q_src1, q_src2, q_dest,
        output q_pop,
        output alu_valid, alu_iss_imm, alu_iss_use_imm, alu_iss_pc,
               alu_iss_src1, alu_iss_src2, alu_iss_dest,
        input  alu_ready,
        output mul_valid, mul_iss_imm, mul_iss_use_imm, mul_iss_pc,
               mul_iss_src1, mul_iss_src2, mul_iss_dest,
        input  mul_ready,
        input  wb_valid, wb_dest, flush,
        output except_out, halted, stall_cnt
    );

    modport slave (
        output q_valid, q_uop, q_imm, q_use_imm, q_pc, q_src1, q_src2, q_dest,
        input  q_pop,
        input  alu_valid, alu_iss_imm, alu_iss_use_imm, alu_iss_pc,
               alu_iss_src1, alu_iss_src2, alu_iss_dest,
        output alu_ready,
        input  mul_valid, mul_iss_imm, mul_iss_use_imm, mul_iss_pc,
               mul_iss_src1, mul_iss_src2, mul_iss_dest,
        output mul_ready,
        output wb_valid, wb_dest, flush,
        input  except_out, halted, stall_cnt
    );
endinterface

// File: rtl/uop_dispatch_sched.sv
// In-order issue scheduler: pops the decode queue head into an ALU or MUL issue slot,
// blocking RAW/WAW hazards with a 32-entry scoreboard; handles halt, flush and illegal uops.
module uop_dispatch_sched #(
    parameter int XLEN    = 32,
    parameter int STALL_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uop_dispatch_sched_if.master bus
);
    localparam logic [6:0] UOP_ALU  = 7'b010_0000;
    localparam logic [6:0] UOP_MUL  = 7'b100_0000;
    localparam logic [6:0] UOP_HALT = 7'b111_1111;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      src1;
        logic [4:0]      src2;
        logic [4:0]      dest;
    } payload_t;

    state_t             state, state_nxt;
    payload_t           head_pl, alu_pl_p0, mul_pl_p0;
    logic               alu_vld_p0, mul_vld_p0;
    logic               except_r;
    logic [31:0]        busy, busy_set, busy_clr, busy_nxt;
    logic [STALL_W-1:0] stall_r;
    logic               is_alu, is_mul, is_halt, is_ill;
    logic               hz, alu_free, mul_free, drained;
    logic               pop, alu_load, mul_load;

    assign head_pl = {bus.q_imm, bus.q_use_imm, bus.q_pc, bus.q_src1, bus.q_src2, bus.q_dest};

    assign is_alu  = (bus.q_uop == UOP_ALU);
    assign is_mul  = (bus.q_uop == UOP_MUL);
    assign is_halt = (bus.q_uop == UOP_HALT);
    assign is_ill  = !(is_alu || is_mul || is_halt);

    // Scoreboard is read as registered: a writeback frees its register one cycle later.
    assign hz = busy[bus.q_src1] | (!bus.q_use_imm & busy[bus.q_src2]) | busy[bus.q_dest];

    assign alu_free = !alu_vld_p0 || bus.alu_ready;
    assign mul_free = !mul_vld_p0 || bus.mul_ready;
    assign drained  = (busy == '0) && !alu_vld_p0 && !mul_vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            RUN: begin
                if (bus.q_valid && !bus.flush) begin
                    if (is_alu)      pop = !hz && alu_free;
                    else if (is_mul) pop = !hz && mul_free;
                    else             pop = 1'b1;
                    if (pop && is_halt) state_nxt = DRAIN;
                end
            end
            DRAIN:   if (drained) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
        if (bus.flush) state_nxt = RUN;
    end

    assign alu_load = pop && is_alu;
    assign mul_load = pop && is_mul;

    // Clears apply before sets so an issue to a register being written back stays busy.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (bus.wb_valid[0]) busy_clr[bus.wb_dest[4:0]] = 1'b1;
        if (bus.wb_valid[1]) busy_clr[bus.wb_dest[9:5]] = 1'b1;
        if (alu_load || mul_load) busy_set[bus.q_dest] = 1'b1;
        busy_nxt    = (busy & ~busy_clr) | busy_set;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            alu_vld_p0 <= 1'b0;
            mul_vld_p0 <= 1'b0;
            except_r   <= 1'b0;
        end else if (bus.flush) begin
            busy       <= '0;
            alu_vld_p0 <= 1'b0;
            mul_vld_p0 <= 1'b0;
            except_r   <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            alu_vld_p0 <= alu_load || (alu_vld_p0 && !bus.alu_ready);
            mul_vld_p0 <= mul_load || (mul_vld_p0 && !bus.mul_ready);
            except_r   <= pop && is_ill;
        end
    end

    // ---- issue slot stage (p0): payload held until the unit accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_pl_p0 <= '0;
            mul_pl_p0 <= '0;
        end else begin
            if (alu_load) alu_pl_p0 <= head_pl;
            if (mul_load) mul_pl_p0 <= head_pl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= '0;
        end else if (bus.q_valid && !pop && (state != HALTED) && (stall_r != '1)) begin
            stall_r <= stall_r + 1'b1;
        end
    end

    // Pop is gated by reset so every output reads zero while rst_n is low.
    assign bus.q_pop           = pop & rst_n;
    assign bus.alu_valid       = alu_vld_p0;
    assign bus.alu_iss_imm     = alu_pl_p0.imm;
    assign bus.alu_iss_use_imm = alu_pl_p0.use_imm;
    assign bus.alu_iss_pc      = alu_pl_p0.pc;
    assign bus.alu_iss_src1    = alu_pl_p0.src1;
    assign bus.alu_iss_src2    = alu_pl_p0.src2;
    assign bus.alu_iss_dest    = alu_pl_p0.dest;
    assign bus.mul_valid       = mul_vld_p0;
    assign bus.mul_iss_imm     = mul_pl_p0.imm;
    assign bus.mul_iss_use_imm = mul_pl_p0.use_imm;
    assign bus.mul_iss_pc      = mul_pl_p0.pc;
    assign bus.mul_iss_src1    = mul_pl_p0.src1;
    assign bus.mul_iss_src2    = mul_pl_p0.src2;
    assign bus.mul_iss_dest    = mul_pl_p0.dest;
    assign bus.except_out      = except_r;
    assign bus.halted          = (state == HALTED);
    assign bus.stall_cnt       = stall_r;
endmodule

// File: tb/tb_uop_dispatch_sched.sv
// Randomized and directed bench for uop_dispatch_sched, checked against a
// cycle-level behavioural model of the scheduling rules.
module tb_uop_dispatch_sched;
    localparam int XLEN    = 32;
    localparam int STALL_W = 6;
    localparam int SMAX    = (1 << STALL_W) - 1;
    localparam logic [6:0] ALU  = 7'b010_0000;
    localparam logic [6:0] MUL  = 7'b100_0000;
    localparam logic [6:0] HALT = 7'b111_1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uop_dispatch_sched_if #(.XLEN(XLEN), .STALL_W(STALL_W)) bus ();

    uop_dispatch_sched #(.XLEN(XLEN), .STALL_W(STALL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          v;
        logic [31:0] imm;
        bit          use_imm;
        logic [31:0] pc;
        logic [4:0]  s1, s2, d;
    } slot_t;

    int    checks = 0;
    int    failures = 0;
    bit    m_busy[32];
    int    m_mode;          // 0 run, 1 drain, 2 halted
    slot_t m_alu, m_mul;
    bit    m_exc;
    int    m_stall;
    bit    exp_pop, dut_pop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_busy();
        for (int r = 0; r < 32; r++) if (m_busy[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_mode  = 0;
        m_alu   = '{default: 0};
        m_mul   = '{default: 0};
        m_exc   = 1'b0;
        m_stall = 0;
    endtask

    // Whether the head may leave the queue this cycle, from the issue rules.
    function automatic bit model_pop();
        bit blocked;
        if (m_mode != 0 || !bus.q_valid || bus.flush) return 1'b0;
        blocked = m_busy[bus.q_src1] || m_busy[bus.q_dest] ||
                  (!bus.q_use_imm && m_busy[bus.q_src2]);
        if (bus.q_uop == ALU) return !blocked && (!m_alu.v || bus.alu_ready);
        if (bus.q_uop == MUL) return !blocked && (!m_mul.v || bus.mul_ready);
        return 1'b1;
    endfunction

    task automatic model_edge(input bit p);
        slot_t head;
        bit    was_drained;
        was_drained = (m_mode == 1) && !m_alu.v && !m_mul.v && !any_busy();
        if (bus.q_valid && !p && m_mode != 2 && m_stall < SMAX) m_stall++;
        if (bus.flush) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            m_alu.v = 1'b0;
            m_mul.v = 1'b0;
            m_exc   = 1'b0;
            m_mode  = 0;
            return;
        end
        if (bus.alu_ready) m_alu.v = 1'b0;
        if (bus.mul_ready) m_mul.v = 1'b0;
        if (bus.wb_valid[0]) m_busy[bus.wb_dest[4:0]] = 1'b0;
        if (bus.wb_valid[1]) m_busy[bus.wb_dest[9:5]] = 1'b0;
        m_exc = 1'b0;
        head = '{1'b1, bus.q_imm, bus.q_use_imm, bus.q_pc, bus.q_src1, bus.q_src2, bus.q_dest};
        if (p) begin
            if (bus.q_uop == ALU || bus.q_uop == MUL) begin
                if (bus.q_uop == ALU) m_alu = head;
                else                  m_mul = head;
                if (bus.q_dest != 5'd0) m_busy[bus.q_dest] = 1'b1;
            end else if (bus.q_uop == HALT) begin
                m_mode = 1;
            end else begin
                m_exc = 1'b1;
            end
        end else if (was_drained) begin
            m_mode = 2;
        end
    endtask

    task automatic check_regs();
        chk("alu_valid",   bus.alu_valid,       m_alu.v);
        chk("alu_imm",     bus.alu_iss_imm,     m_alu.imm);
        chk("alu_use_imm", bus.alu_iss_use_imm, m_alu.use_imm);
        chk("alu_pc",      bus.alu_iss_pc,      m_alu.pc);
        chk("alu_src1",    bus.alu_iss_src1,    m_alu.s1);
        chk("alu_src2",    bus.alu_iss_src2,    m_alu.s2);
        chk("alu_dest",    bus.alu_iss_dest,    m_alu.d);
        chk("mul_valid",   bus.mul_valid,       m_mul.v);
        chk("mul_imm",     bus.mul_iss_imm,     m_mul.imm);
        chk("mul_use_imm", bus.mul_iss_use_imm, m_mul.use_imm);
        chk("mul_pc",      bus.mul_iss_pc,      m_mul.pc);
        chk("mul_src1",    bus.mul_iss_src1,    m_mul.s1);
        chk("mul_src2",    bus.mul_iss_src2,    m_mul.s2);
        chk("mul_dest",    bus.mul_iss_dest,    m_mul.d);
        chk("except_out",  bus.except_out,      m_exc);
        chk("halted",      bus.halted,          m_mode == 2);
        chk("stall_cnt",   bus.stall_cnt,       m_stall);
    endtask

    // One clock: compare pop mid-cycle, advance the model at the edge, compare registers.
    task automatic cycle();
        @(negedge clk);
        exp_pop = model_pop();
        dut_pop = bus.q_pop;
        chk("q_pop", dut_pop, exp_pop);
        @(posedge clk);
        model_edge(exp_pop);
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        bus.q_valid = 1'b0;
        bus.flush = 1'b0;
        bus.wb_valid = 2'b00;
        bus.wb_dest = '0;
        bus.alu_ready = 1'b0;
        bus.mul_ready = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_rst_pop"},    bus.q_pop,       0);
        chk({tag, "_rst_alu_v"},  bus.alu_valid,   0);
        chk({tag, "_rst_mul_v"},  bus.mul_valid,   0);
        chk({tag, "_rst_exc"},    bus.except_out,  0);
        chk({tag, "_rst_halted"}, bus.halted,      0);
        chk({tag, "_rst_stall"},  bus.stall_cnt,   0);
        chk({tag, "_rst_alu_pc"}, bus.alu_iss_pc,  0);
        chk({tag, "_rst_mul_im"}, bus.mul_iss_imm, 0);
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic [6:0] uop, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [4:0] d, input bit use_imm);
        bus.q_uop     = uop;
        bus.q_src1    = s1;
        bus.q_src2    = s2;
        bus.q_dest    = d;
        bus.q_use_imm = use_imm;
        bus.q_imm     = $urandom;
        bus.q_pc      = $urandom;
    endtask

    task automatic rand_head();
        int r;
        logic [6:0] u;
        r = $urandom_range(99);
        if (r < 45)      u = ALU;
        else if (r < 80) u = MUL;
        else if (r < 84) u = HALT;
        else begin
            u = 7'($urandom);
            if (u == ALU || u == MUL || u == HALT) u = 7'h01;
        end
        set_head(u, 5'($urandom_range(7)), 5'($urandom_range(7)),
                 5'($urandom_range(7)), 1'($urandom_range(1)));
    endtask

    initial begin
        idle_inputs();
        set_head(ALU, 0, 0, 0, 0);

        // ADD x3 = x1 + x2 issues at once; x3 then blocks a dependent ADD
        do_reset("t1");
        set_head(ALU, 1, 2, 3, 0);
        bus.q_valid = 1'b1;
        bus.alu_ready = 1'b1;
        cycle();
        chk("t1_pop", dut_pop, 1);
        chk("t1_alu_valid", bus.alu_valid, 1);
        chk("t1_dest", bus.alu_iss_dest, 3);
        set_head(ALU, 3, 2, 4, 0);
        cycle();
        chk("t1_busy3_blocks", dut_pop, 0);

        // MUL x5 then dependent ADD; MUL writeback 4 cycles after issue
        do_reset("t2");
        bus.mul_ready = 1'b1;
        bus.alu_ready = 1'b1;
        set_head(MUL, 1, 2, 5, 0);
        bus.q_valid = 1'b1;
        cycle();
        chk("t2_mul_pop", dut_pop, 1);
        set_head(ALU, 5, 1, 6, 0);
        for (int k = 1; k <= 5; k++) begin
            bus.wb_valid = (k == 4) ? 2'b10 : 2'b00;
            bus.wb_dest  = {5'd5, 5'd0};
            cycle();
            chk($sformatf("t2_pop_c%0d", k), dut_pop, (k == 5));
        end
        chk("t2_stall", bus.stall_cnt, 4);
        bus.wb_valid = 2'b00;

        // Two MULs while the MUL unit is not ready for 3 cycles
        do_reset("t3");
        bus.mul_ready = 1'b1;
        set_head(MUL, 1, 2, 8, 0);
        bus.q_valid = 1'b1;
        cycle();
        set_head(MUL, 3, 4, 9, 0);
        bus.mul_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("t3_hold_pop", dut_pop, 0);
            chk("t3_hold_dest", bus.mul_iss_dest, 8);
        end
        bus.mul_ready = 1'b1;
        cycle();
        chk("t3_ready_pop", dut_pop, 1);
        chk("t3_new_dest", bus.mul_iss_dest, 9);

        // Illegal uop
        do_reset("t4");
        set_head(7'b000_0001, 1, 2, 3, 0);
        bus.q_valid = 1'b1;
        cycle();
        chk("t4_pop", dut_pop, 1);
        chk("t4_exc", bus.except_out, 1);
        chk("t4_no_slot", {bus.alu_valid, bus.mul_valid}, 0);
        bus.q_valid = 1'b0;
        cycle();
        chk("t4_exc_pulse", bus.except_out, 0);

        // Halt with x7 busy: drain, halt, then flush back to RUN
        do_reset("t5");
        set_head(ALU, 1, 2, 7, 0);
        bus.q_valid = 1'b1;
        cycle();
        bus.alu_ready = 1'b1;
        set_head(HALT, 0, 0, 0, 0);
        cycle();
        chk("t5_halt_pop", dut_pop, 1);
        set_head(ALU, 1, 2, 4, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_drain_halted", bus.halted, 0);
            chk("t5_drain_pop", dut_pop, 0);
        end
        bus.wb_valid = 2'b01;
        bus.wb_dest = {5'd0, 5'd7};
        cycle();
        chk("t5_wb_edge_halted", bus.halted, 0);
        bus.wb_valid = 2'b00;
        cycle();
        chk("t5_halted", bus.halted, 1);
        cycle();
        chk("t5_halted_pop", dut_pop, 0);
        bus.flush = 1'b1;
        cycle();
        chk("t5_flush_halted", bus.halted, 0);
        bus.flush = 1'b0;
        cycle();
        chk("t5_run_pop", dut_pop, 1);

        // Writes to x0 never create hazards; then reset in the middle of issue
        do_reset("t6");
        bus.alu_ready = 1'b1;
        set_head(ALU, 1, 0, 0, 1);
        bus.q_valid = 1'b1;
        cycle();
        set_head(ALU, 0, 0, 2, 0);
        cycle();
        chk("t6_x0_no_stall", dut_pop, 1);
        bus.alu_ready = 1'b0;
        set_head(ALU, 3, 4, 6, 0);
        cycle();
        @(negedge clk);
        #1;
        do_reset("t6mid");

        // Randomized traffic including hazards, back-pressure, halts, flushes
        rand_head();
        for (int i = 0; i < 4000; i++) begin
            bus.q_valid   = ($urandom_range(9) < 8);
            bus.alu_ready = ($urandom_range(3) != 0);
            bus.mul_ready = ($urandom_range(3) != 0);
            bus.wb_valid  = 2'($urandom_range(3));
            bus.wb_dest   = {5'($urandom_range(7)), 5'($urandom_range(7))};
            bus.flush     = ($urandom_range(59) == 0);
            cycle();
            if (exp_pop) rand_head();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
